// File: rtl/arm_ctrl_pkg.sv
// Shared ARM decode constants, control bundle and decoder.
// Used by ctrl_unit_mc and cond_check.
package arm_ctrl_pkg;

  typedef enum logic {
    S_IDLE,
    S_MEM_WAIT
  } state_t;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_MOV  = 4'b1101;
  localparam logic [3:0] OP_MVN  = 4'b1111;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_ADC  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SBC  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_ORR  = 4'b1100;
  localparam logic [3:0] OP_EOR  = 4'b0001;
  localparam logic [3:0] OP_CMP  = 4'b1010;
  localparam logic [3:0] OP_TST  = 4'b1000;
  localparam logic [3:0] OP_LDST = 4'b0100;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_MI = 4'b0100;
  localparam logic [3:0] CC_PL = 4'b0101;
  localparam logic [3:0] CC_VS = 4'b0110;
  localparam logic [3:0] CC_VC = 4'b0111;
  localparam logic [3:0] CC_HI = 4'b1000;
  localparam logic [3:0] CC_LS = 4'b1001;
  localparam logic [3:0] CC_GE = 4'b1010;
  localparam logic [3:0] CC_LT = 4'b1011;
  localparam logic [3:0] CC_GT = 4'b1100;
  localparam logic [3:0] CC_LE = 4'b1101;
  localparam logic [3:0] CC_AL = 4'b1110;
  localparam logic [3:0] CC_NV = 4'b1111;

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       branch;
    logic       s_out;
  } ctrl_t;

  function automatic ctrl_t decode(
    input logic [1:0] md,
    input logic [3:0] op,
    input logic       s
  );
    ctrl_t c;
    logic  hit;
    c   = '0;
    hit = 1'b1;
    if (md == MODE_DP) begin
      case (op)
        OP_MOV:  c.exe_cmd = CMD_MOV;
        OP_MVN:  c.exe_cmd = CMD_MVN;
        OP_ADD:  c.exe_cmd = CMD_ADD;
        OP_ADC:  c.exe_cmd = CMD_ADC;
        OP_SUB:  c.exe_cmd = CMD_SUB;
        OP_SBC:  c.exe_cmd = CMD_SBC;
        OP_AND:  c.exe_cmd = CMD_AND;
        OP_ORR:  c.exe_cmd = CMD_ORR;
        OP_EOR:  c.exe_cmd = CMD_EOR;
        OP_CMP:  c.exe_cmd = CMD_SUB;
        OP_TST:  c.exe_cmd = CMD_AND;
        default: hit = 1'b0;
      endcase
      if (hit) begin
        c.wb_en = (op != OP_CMP) && (op != OP_TST);
        c.s_out = s;
      end
    end else if (md == MODE_MEM && op == OP_LDST) begin
      c.exe_cmd   = CMD_ADD;
      c.mem_read  = s;
      c.mem_write = !s;
      c.wb_en     = s;
    end else if (md == MODE_BR && !op[3]) begin
      c.branch = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/ctrl_unit_mc_cond_check.sv
// ARM condition evaluation (combinational).
// Ports: cond, sr_flags {N,Z,C,V} in; pass out.
module cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] sr_flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = sr_flags[3];
  assign z = sr_flags[2];
  assign c = sr_flags[1];
  assign v = sr_flags[0];

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      CC_EQ: pass = z;
      CC_NE: pass = !z;
      CC_CS: pass = c;
      CC_CC: pass = !c;
      CC_MI: pass = n;
      CC_PL: pass = !n;
      CC_VS: pass = v;
      CC_VC: pass = !v;
      CC_HI: pass = c && !z;
      CC_LS: pass = !c || z;
      CC_GE: pass = (n == v);
      CC_LT: pass = (n != v);
      CC_GT: pass = !z && (n == v);
      CC_LE: pass = z || (n != v);
      CC_AL: pass = 1'b1;
      CC_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_unit_mc.sv
// ID/EX control unit: decode, condition check, multi-cycle memory wait.
// In: instr fields, flags, freeze/flush, mem_ready. Out: registered controls, busy, mem_err.
module ctrl_unit_mc
  import arm_ctrl_pkg::*;
#(
  parameter int CMD_W       = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [1:0]       mode,
  input  logic [3:0]       op_code,
  input  logic             s,
  input  logic [3:0]       cond,
  input  logic [3:0]       sr_flags,
  input  logic             freeze,
  input  logic             flush,
  input  logic             mem_ready,
  output logic [CMD_W-1:0] exe_cmd,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_en,
  output logic             branch,
  output logic             s_out,
  output logic             ctrl_valid,
  output logic             busy,
  output logic             mem_err
);

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d, dec;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pass;

  cond_check u_cond (
    .cond     (cond),
    .sr_flags (sr_flags),
    .pass     (pass)
  );

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    dec     = decode(mode, op_code, s);
    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (flush) begin
          ctrl_d  = '0;
          valid_d = 1'b0;
        end else if (freeze) begin
          ctrl_d  = ctrl_q;
          valid_d = valid_q;
        end else if (instr_valid && pass) begin
          ctrl_d  = dec;
          valid_d = 1'b1;
          if (dec.mem_read || dec.mem_write) begin
            state_d = S_MEM_WAIT;
            busy_d  = 1'b1;
            cnt_d   = '0;
          end
        end else begin
          ctrl_d  = '0;
          valid_d = 1'b0;
        end
      end
      S_MEM_WAIT: begin
        // ready wins over a coinciding timeout
        if (mem_ready || cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          ctrl_d  = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          err_d   = !mem_ready;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign exe_cmd    = CMD_W'(ctrl_q.exe_cmd);
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign wb_en      = ctrl_q.wb_en;
  assign branch     = ctrl_q.branch;
  assign s_out      = ctrl_q.s_out;
  assign ctrl_valid = valid_q;
  assign busy       = busy_q;
  assign mem_err    = err_q;

endmodule
